// File: rtl/fifo_v3.sv
// Synchronous single-clock FIFO with optional show-ahead read, occupancy count,
// programmable almost flags, sticky overflow/underflow and synchronous flush.
module fifo_v3 #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int SHOW_AHEAD = 0,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wren,
  input  logic                    rden,
  input  logic                    flush,
  input  logic                    clr_err,
  input  logic [DATA_WIDTH-1:0]   i_data,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] head;
  logic                  rd_ok, wr_ok, rd_acc, wr_acc;
  logic                  ov_set, un_set;

  // The wrap bit makes the pointer difference the exact occupancy, 0..DEPTH.
  assign count        = wr_ptr - rd_ptr;
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  assign head   = mem[rd_ptr[AW-1:0]];
  assign rd_ok  = rden & ~empty;
  assign wr_ok  = wren & (~full | rd_ok);
  assign rd_acc = rd_ok & ~flush;
  assign wr_acc = wr_ok & ~flush;
  assign ov_set = wren & ~wr_ok & ~flush;
  assign un_set = rden & empty & ~flush;

  assign o_data = (SHOW_AHEAD != 0 && !empty) ? head : data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      data_q    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        // Show-ahead keeps presenting the word that was visible before the flush.
        if (SHOW_AHEAD != 0 && !empty) data_q <= head;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
        if (rd_acc) begin
          rd_ptr <= rd_ptr + 1'b1;
          data_q <= head;
        end
      end
      overflow  <= ov_set | (overflow & ~clr_err);
      underflow <= un_set | (underflow & ~clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: tb/tb_fifo_v3.sv
// Randomised + directed bench for fifo_v3: a queue-based reference model drives a
// read-data scoreboard and per-cycle flag checks on a normal and a show-ahead instance.
module tb_fifo_v3;
  localparam int DEPTH = 8;
  localparam int DW    = 8;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wren = 1'b0, rden = 1'b0, flush = 1'b0, clr_err = 1'b0;
  logic [DW-1:0] i_data = '0;

  logic [DW-1:0] o_data0, o_data1;
  logic full0, empty0, af0, ae0, ov0, un0;
  logic full1, empty1, af1, ae1, ov1, un1;
  logic [CW-1:0] count0, count1;

  fifo_v3 #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .SHOW_AHEAD(0), .AF_THRESH(AF), .AE_THRESH(AE)) dut0 (
    .clk(clk), .rst(rst), .wren(wren), .rden(rden), .flush(flush), .clr_err(clr_err),
    .i_data(i_data), .o_data(o_data0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(count0),
    .overflow(ov0), .underflow(un0));

  fifo_v3 #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .SHOW_AHEAD(1), .AF_THRESH(AF), .AE_THRESH(AE)) dut1 (
    .clk(clk), .rst(rst), .wren(wren), .rden(rden), .flush(flush), .clr_err(clr_err),
    .i_data(i_data), .o_data(o_data1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(count1),
    .overflow(ov1), .underflow(un1));

  always #5 clk = ~clk;

  // Reference model
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] sa_last = '0;
  bit m_ov = 1'b0, m_un = 1'b0;
  bit pend = 1'b0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit rd_ok, wr_ok, nov, nun;
    nov = 1'b0;
    nun = 1'b0;
    if (flush) begin
      if (mq.size() > 0) sa_last = mq[0];
      mq.delete();
    end else begin
      rd_ok = rden && (mq.size() > 0);
      wr_ok = wren && ((mq.size() < DEPTH) || rd_ok);
      nov   = wren && !wr_ok;
      nun   = rden && (mq.size() == 0);
      if (rd_ok) begin
        sa_last = mq.pop_front();
        exp_q.push_back(sa_last);
      end
      if (wr_ok) mq.push_back(i_data);
    end
    m_ov = nov | (m_ov & !clr_err);
    m_un = nun | (m_un & !clr_err);
  endtask

  task automatic step(input bit w, input bit r, input bit f, input bit c, input logic [DW-1:0] d);
    @(negedge clk);
    wren = w; rden = r; flush = f; clr_err = c; i_data = d;
    @(posedge clk);
    model_edge();
  endtask

  task automatic check_reset();
    chk("rst_count0", int'(count0), 0);
    chk("rst_count1", int'(count1), 0);
    chk("rst_empty", int'(empty0), 1);
    chk("rst_full", int'(full0), 0);
    chk("rst_ae", int'(ae0), 1);
    chk("rst_af", int'(af0), 0);
    chk("rst_ovf", int'(ov0), 0);
    chk("rst_unf", int'(un0), 0);
    chk("rst_odata0", int'(o_data0), 0);
    chk("rst_odata1", int'(o_data1), 0);
  endtask

  // Monitor: a read handshake on the normal-mode DUT yields a word one cycle later.
  always @(posedge clk) pend = !rst && rden && !empty0 && !flush;

  always @(negedge clk) begin
    if (!rst) begin
      int n;
      n = mq.size();
      if (pend) begin
        if (exp_q.size() == 0) chk("rdata_unexpected", 1, 0);
        else chk("rdata", int'(o_data0), int'(exp_q.pop_front()));
      end
      chk("count0", int'(count0), n);
      chk("count1", int'(count1), n);
      chk("full", int'(full0), int'(n == DEPTH));
      chk("empty", int'(empty0), int'(n == 0));
      chk("almost_full", int'(af0), int'(n >= AF));
      chk("almost_empty", int'(ae0), int'(n <= AE));
      chk("overflow0", int'(ov0), int'(m_ov));
      chk("underflow0", int'(un0), int'(m_un));
      chk("overflow1", int'(ov1), int'(m_ov));
      chk("underflow1", int'(un1), int'(m_un));
      chk("flags1", int'({full1, empty1, af1, ae1}),
          int'({n == DEPTH, n == 0, n >= AF, n <= AE}));
      chk("sa_odata", int'(o_data1), int'((n > 0) ? mq[0] : sa_last));
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset();
    rst = 1'b0;

    // Fill to full, then one overflowing write
    for (int i = 1; i <= DEPTH; i++) step(1, 0, 0, 0, DW'(i));
    step(1, 0, 0, 0, 8'h09);
    // Write+read at full (also clears the sticky overflow), then drain
    step(1, 1, 0, 1, 8'hAA);
    repeat (DEPTH) step(0, 1, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);

    // Underflow set, clear, and clear losing to a simultaneous error
    step(0, 1, 0, 0, 8'h00);
    step(0, 0, 0, 1, 8'h00);
    step(0, 1, 0, 1, 8'h00);
    step(0, 0, 0, 1, 8'h00);

    // Show-ahead visibility and hold after pop
    step(1, 0, 0, 0, 8'h5C);
    step(0, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);

    // Flush with a concurrent write
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, DW'(8'h30 + i));
    step(1, 0, 1, 0, 8'h77);
    step(0, 0, 0, 0, 8'h00);

    // Random traffic
    repeat (500) begin
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5, DW'($urandom));
    end
    repeat (DEPTH + 2) step(0, 1, 0, 0, 8'h00);
    step(0, 0, 0, 1, 8'h00);

    // Asynchronous reset mid-cycle with data inside
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, DW'(8'h40 + i));
    #2;
    rst = 1'b1;
    wren = 1'b0; rden = 1'b0; flush = 1'b0; clr_err = 1'b0;
    mq.delete();
    exp_q.delete();
    m_ov = 1'b0;
    m_un = 1'b0;
    sa_last = '0;
    #1;
    check_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 0, 0, 8'h11);
    step(0, 1, 0, 0, 8'h00);
    #1;
    chk("post_reset_odata", int'(o_data0), 8'h11);
    step(0, 0, 0, 0, 8'h00);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
